sr_decode_stage: RTL
====================

Name: sr_decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the schoolRISCV core family, placed between instruction fetch and register-file read.
- Splits a 32-bit RV32I instruction into its fields and classifies the format (R/I/S/B/U/J).
- Produces one muxed immediate sign-extended to XLEN and flags illegal encodings.
- Decoded results are buffered in a 2-entry skid FIFO with valid/ready handshakes on both sides, plus a flush and an output-handshake counter.

Parameters:
- XLEN, 32, width of pc and immediate; legal values 32 or 64; immediates sign-extend to XLEN.
- CNT_W, 32, width of decoded_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  pc of head entry
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_f3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_f7  out  7  instr[31:25]
- out_fmt  out  3  imm_fmt_t: R=0, I=1, S=2, B=3, U=4, J=5
- out_imm  out  XLEN  selected immediate
- out_illegal  out  1  unsupported opcode or instr[1:0] != 2'b11
- decoded_cnt  out  CNT_W  count of output handshakes

Behaviour:
- Reset (async, rst=1): FIFO count=0, rd/wr pointers=0, out_valid=0, in_ready=0 while rst is high, decoded_cnt=0. All payload outputs are 0.
- Decode is combinational on in_instr at the input. Decoded fields are written into the buffer on an accept (in_valid & in_ready).
- Format by opcode:
  - 0110111 LUI → U; 0010111 AUIPC → U
  - 1101111 JAL → J
  - 1100111 JALR → I; 0000011 LOAD → I; 0010011 OP-IMM → I; 1110011 SYSTEM → I
  - 1100011 BRANCH → B
  - 0100011 STORE → S
  - 0110011 OP → R
  - any other opcode, or instr[1:0] != 2'b11 → fmt=R, imm=0, illegal=1
- Immediates, all sign-extended from instr[31] to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R → 0
- Buffer: 2 entries, in-order.
  - in_ready = (count < 2) & ~rst. in_ready is registered from count, so it has no combinational path from out_ready.
  - out_valid = (count != 0).
  - Latency: an accept into an empty buffer appears on out_valid the next cycle.
  - Throughput: 1 per cycle when out_ready is held high.
- Simultaneous accept and output handshake: count unchanged, both pointers advance.
- Full (count=2): in_ready=0 and in_valid is ignored. Outputs stay stable while out_valid & ~out_ready.
- Empty: out_valid=0. Payload holds its last value; it is don't-care for verification.
- flush=1 takes priority:
  - next count=0 and pointers reset.
  - Any accept or output handshake in the same cycle is discarded.
  - decoded_cnt does not increment in a flush cycle and is not cleared by flush.
- decoded_cnt increments on out_valid & out_ready & ~flush and wraps modulo 2^CNT_W.
- Reset asserted mid-transfer clears everything immediately. After release, in_ready rises on the first clock edge.

Decomposition:
- Package sr_decode_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM)
  - imm_fmt_t enum (3 bits)
  - decoded-entry packed struct, parametrised by XLEN via the module
- Sub-module sr_imm_gen: combinational, parameter XLEN, maps instr → fmt, imm, illegal.
- The FIFO stays in the top as two entry registers plus pointers.

Test Plan:
- Reset, then addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, fmt=I, rd=1, imm=0xFFFFFFFF, illegal=0, decoded_cnt=1.
- Back-to-back stream, out_ready=1:
  - sw x2,8(x1) 0x0020A423 → S, imm=8
  - beq x0,x0,-8 0xFE000CE3 → B, imm=0xFFFFFFF8
  - lui x5,0x12345 0x123452B7 → U, imm=0x12345000
  - jal x1,-4 0xFFDFF0EF → J, imm=0xFFFFFFFC
  - Expect one result per cycle, in order.
- out_ready=0, push 3 instructions → in_ready drops after 2 accepts and the third is held upstream. out_ready=1 → entries drain in order, and the third is accepted the cycle after space frees.
- instr 0x00000000 and 0x0000007F → illegal=1, fmt=R, imm=0. Fields still pass through.
- With 2 entries buffered, flush=1 together with in_valid=1 → next cycle out_valid=0, count=0, decoded_cnt unchanged.
- XLEN=64 with addi -1 → imm=0xFFFFFFFFFFFFFFFF. lui 0x80000 (0x800002B7) → imm=0xFFFFFFFF80000000. rst pulsed mid-stream → out_valid=0 and decoded_cnt=0 asynchronously.

Source files
------------

// File: rtl/sr_decode_pkg.sv
// Shared opcode constants, immediate-format encoding and the XLEN-independent
// part of a decoded entry for the schoolRISCV decode stage.
package sr_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Buffer depth; count is 2 bits wide so it can hold 0..2.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_t;

    // Fixed-width instruction fields; pc and imm depend on XLEN and are
    // wrapped around this struct inside the stage.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] f7;
        imm_fmt_t   fmt;
        logic       illegal;
    } dec_fields_t;

    // Raw field split; fields pass through even for illegal encodings.
    function automatic dec_fields_t split_fields(input logic [31:0] instr,
                                                 input imm_fmt_t    fmt,
                                                 input logic        illegal);
        dec_fields_t f;
        f.opcode  = instr[6:0];
        f.rd      = instr[11:7];
        f.f3      = instr[14:12];
        f.rs1     = instr[19:15];
        f.rs2     = instr[24:20];
        f.f7      = instr[31:25];
        f.fmt     = fmt;
        f.illegal = illegal;
        return f;
    endfunction

endpackage

// File: rtl/sr_imm_gen.sv
// Combinational format classifier and immediate generator. Every immediate
// is sign-extended from instr[31] to XLEN; unknown encodings yield R/0/illegal.
module sr_imm_gen
    import sr_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify by opcode; the low two bits must be 2'b11 for any 32-bit RV32I op.
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
            OPC_JAL:                                   fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: fmt = FMT_I;
            OPC_BRANCH:                                fmt = FMT_B;
            OPC_STORE:                                 fmt = FMT_S;
            OPC_OP:                                    fmt = FMT_R;
            default:                                   illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            fmt     = FMT_R;
            illegal = 1'b1;
        end
    end

    // Signed size casts sign-extend each raw immediate to XLEN.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = XLEN'(imm_i);
            FMT_S:   imm = XLEN'(imm_s);
            FMT_B:   imm = XLEN'(imm_b);
            FMT_U:   imm = XLEN'(imm_u);
            FMT_J:   imm = XLEN'(imm_j);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/sr_decode_stage.sv
// Registered RV32I decode stage: decodes at the input, buffers results in a
// 2-entry in-order skid FIFO with valid/ready on both sides, supports flush
// and counts output handshakes.
module sr_decode_stage
    import sr_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_f3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_f7,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decoded_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } entry_t;

    imm_fmt_t         dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    entry_t           in_entry;
    entry_t           head;

    entry_t           ent_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    sr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Assemble the entry that is written on an accept.
    always_comb begin
        in_entry     = '0;
        in_entry.pc  = in_pc;
        in_entry.imm = dec_imm;
        in_entry.f   = split_fields(in_instr, dec_fmt, dec_illegal);
    end

    // Flush wins over both handshakes, so neither side makes progress.
    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next occupancy; in_ready is registered from this value so it never
    // depends combinationally on out_ready.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) ent_q[i] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            count      <= count_nxt;
            in_ready_q <= (count_nxt < FIFO_DEPTH);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    ent_q[wr_ptr] <= in_entry;
                    wr_ptr        <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Output handshake counter; flush neither counts nor clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 1'b1;
    end

    assign head        = ent_q[rd_ptr];
    assign in_ready    = in_ready_q;
    assign out_valid   = (count != 2'd0);
    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_opcode  = head.f.opcode;
    assign out_rd      = head.f.rd;
    assign out_f3      = head.f.f3;
    assign out_rs1     = head.f.rs1;
    assign out_rs2     = head.f.rs2;
    assign out_f7      = head.f.f7;
    assign out_fmt     = head.f.fmt;
    assign out_illegal = head.f.illegal;
    assign decoded_cnt = cnt_q;

endmodule
